// File: rtl/frame_source.sv
// frame_source: serial frame generator feeding a bit-to-code converter.
// Each frame is a fixed preamble, a PRBS-15 payload and a zero-filled gap,
// one bit every BIT_DIV clocks. Frames repeat back-to-back while en is high.
// Ports:
//   CLK         system clock, rising edge
//   Rst         asynchronous active-high reset
//   en          frame enable, sampled each cycle
//   Bit         registered serial bit, held between strobes
//   bit_stb     one-cycle pulse when Bit takes a new value
//   frame_start one-cycle pulse with the strobe of preamble bit 0
//   busy        high whenever the generator is not idle
//   frame_cnt   count of frames started, wraps at 16 bits
module frame_source #(
    parameter int unsigned BIT_DIV   = 8,
    parameter int unsigned PRE_LEN   = 32,
    parameter logic [31:0] PRE_WORD  = 32'h1ACFFC1D,
    parameter int unsigned PAY_LEN   = 256,
    parameter int unsigned GAP_LEN   = 16,
    parameter logic [14:0] LFSR_SEED = 15'h7FFF
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        en,
    output logic        Bit,
    output logic        bit_stb,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

    localparam int unsigned MAX_A   = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
    localparam int unsigned MAX_LEN = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN);
    localparam int unsigned DIV_W   = $clog2(BIT_DIV);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0]   PRE_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]   PAY_LAST = CNT_W'(PAY_LEN - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(GAP_LEN - 1);
    localparam logic [PRE_LEN-1:0] PRE_BITS = PRE_WORD[PRE_LEN-1:0];

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_idx;
    logic [14:0]        r_lfsr;
    logic [PRE_LEN-1:0] r_pre_sr;
    logic               r_bit;
    logic               r_stb;
    logic               r_fs;
    logic               r_busy;
    logic [15:0]        r_cnt;

    logic w_bit_end;
    logic w_fb;

    assign w_bit_end = (r_div == DIV_LAST);
    assign w_fb      = r_lfsr[14] ^ r_lfsr[13];

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_idx    <= '0;
            r_lfsr   <= LFSR_SEED;
            r_pre_sr <= '0;
            r_bit    <= 1'b0;
            r_stb    <= 1'b0;
            r_fs     <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_stb <= 1'b0;
            r_fs  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_div <= '0;
                    r_bit <= 1'b0;
                    if (en) begin
                        r_state  <= PRE;
                        r_idx    <= '0;
                        r_bit    <= PRE_BITS[PRE_LEN-1];
                        r_pre_sr <= PRE_BITS << 1;
                        r_stb    <= 1'b1;
                        r_fs     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    if (!w_bit_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        // Bit period ends here: the next bit goes out on this edge.
                        r_div <= '0;
                        r_stb <= 1'b1;
                        case (r_state)
                            PRE: begin
                                if (r_idx == PRE_LAST) begin
                                    r_state <= PAY;
                                    r_idx   <= '0;
                                    r_bit   <= r_lfsr[14];
                                    r_lfsr  <= {r_lfsr[13:0], w_fb};
                                end else begin
                                    r_idx    <= r_idx + 1'b1;
                                    r_bit    <= r_pre_sr[PRE_LEN-1];
                                    r_pre_sr <= r_pre_sr << 1;
                                end
                            end
                            PAY: begin
                                if (r_idx == PAY_LAST) begin
                                    r_state <= GAP;
                                    r_idx   <= '0;
                                    r_bit   <= 1'b0;
                                end else begin
                                    r_idx  <= r_idx + 1'b1;
                                    r_bit  <= r_lfsr[14];
                                    r_lfsr <= {r_lfsr[13:0], w_fb};
                                end
                            end
                            GAP: begin
                                if (r_idx != GAP_LAST) begin
                                    r_idx <= r_idx + 1'b1;
                                    r_bit <= 1'b0;
                                end else if (en) begin
                                    // Back-to-back frame, no idle cycle in between.
                                    r_state  <= PRE;
                                    r_idx    <= '0;
                                    r_bit    <= PRE_BITS[PRE_LEN-1];
                                    r_pre_sr <= PRE_BITS << 1;
                                    r_fs     <= 1'b1;
                                    r_cnt    <= r_cnt + 16'd1;
                                end else begin
                                    r_state <= IDLE;
                                    r_idx   <= '0;
                                    r_bit   <= 1'b0;
                                    r_busy  <= 1'b0;
                                    r_stb   <= 1'b0;
                                end
                            end
                            default: begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_stb   <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign Bit         = r_bit;
    assign bit_stb     = r_stb;
    assign frame_start = r_fs;
    assign busy        = r_busy;
    assign frame_cnt   = r_cnt;

endmodule

// File: tb/tb_frame_source.sv
// Scoreboard bench for frame_source: stimulus pushes expected bits, forked
// monitors pop and compare on every bit_stb. Second instance uses a small
// configuration (BIT_DIV=2, 4-bit preamble 4'hA, 8-bit payload, 4-bit gap).
module tb_frame_source;

    typedef struct packed {
        logic b;   // expected Bit
        logic fs;  // expected frame_start
        logic sp;  // check spacing from previous strobe
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        bit1, stb1, fs1, busy1;
    logic [15:0] cnt1;

    logic        rst2 = 1'b1;
    logic        en2  = 1'b0;
    logic        bit2, stb2, fs2, busy2;
    logic [15:0] cnt2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_stb1  = 0;
    int          n_stb2  = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] pre_w   = 32'h1ACFFC1D;
    logic [15:0] fffe    = 16'hFFFE;
    logic [14:0] m_lfsr  = 15'h7FFF;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_source u_dut (
        .CLK         (clk),
        .Rst         (rst),
        .en          (en),
        .Bit         (bit1),
        .bit_stb     (stb1),
        .frame_start (fs1),
        .busy        (busy1),
        .frame_cnt   (cnt1)
    );

    frame_source #(
        .BIT_DIV   (2),
        .PRE_LEN   (4),
        .PRE_WORD  (32'hA),
        .PAY_LEN   (8),
        .GAP_LEN   (4),
        .LFSR_SEED (15'h7FFF)
    ) u_dut2 (
        .CLK         (clk),
        .Rst         (rst2),
        .en          (en2),
        .Bit         (bit2),
        .bit_stb     (stb2),
        .frame_start (fs2),
        .busy        (busy2),
        .frame_cnt   (cnt2)
    );

    function automatic exp_t mk(input logic b, input logic fs, input logic sp);
        exp_t e;
        e.b  = b;
        e.fs = fs;
        e.sp = sp;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Default-configuration frame; fresh selects the hand value 0xFFFE for
    // the first 16 payload bits after a reset seed load.
    task automatic push_frame1(input bit from_idle, input bit fresh);
        logic pb;
        for (int i = 0; i < 32; i++) q1.push_back(mk(pre_w[31-i], i == 0, !(i == 0 && from_idle)));
        for (int i = 0; i < 256; i++) begin
            pb = m_lfsr[14];
            if (fresh && i < 16) pb = fffe[15-i];
            q1.push_back(mk(pb, 1'b0, 1'b1));
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
        end
        for (int i = 0; i < 16; i++) q1.push_back(mk(1'b0, 1'b0, 1'b1));
    endtask

    task automatic push_small(input logic [15:0] bits, input bit from_idle);
        for (int i = 0; i < 16; i++) q2.push_back(mk(bits[15-i], i == 0, !(i == 0 && from_idle)));
    endtask

    task automatic mon1();
        exp_t e;
        int   last = 0;
        forever begin
            @(negedge clk);
            if (stb1 === 1'b1) begin
                n_stb1++;
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon1_unexpected_strobe: got strobe at cycle %0d expected none", cyc);
                end else begin
                    e = q1.pop_front();
                    if (bit1 !== e.b || fs1 !== e.fs || busy1 !== 1'b1 ||
                        (e.sp && (cyc - last) != 8)) begin
                        n_fail++;
                        $display("FAIL mon1_bit %0d: got bit=%b fs=%b busy=%b gap=%0d expected bit=%b fs=%b busy=1 gap=8",
                                 n_stb1, bit1, fs1, busy1, cyc - last, e.b, e.fs);
                    end
                end
                last = cyc;
            end
        end
    endtask

    task automatic mon2();
        exp_t e;
        int   last = 0;
        forever begin
            @(negedge clk);
            if (stb2 === 1'b1) begin
                n_stb2++;
                n_tests++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon2_unexpected_strobe: got strobe at cycle %0d expected none", cyc);
                end else begin
                    e = q2.pop_front();
                    if (bit2 !== e.b || fs2 !== e.fs || busy2 !== 1'b1 ||
                        (e.sp && (cyc - last) != 2)) begin
                        n_fail++;
                        $display("FAIL mon2_bit %0d: got bit=%b fs=%b busy=%b gap=%0d expected bit=%b fs=%b busy=1 gap=2",
                                 n_stb2, bit2, fs2, busy2, cyc - last, e.b, e.fs);
                    end
                end
                last = cyc;
            end
        end
    endtask

    initial begin
        int k, t1, t2, idle_seen, n, base;
        fork
            mon1();
            mon2();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_bit", bit1, 0);
        check("rst_stb", stb1, 0);
        check("rst_fs", fs1, 0);
        check("rst_busy", busy1, 0);
        check("rst_cnt", cnt1, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("idle_busy", busy1, 0);
        check("idle_cnt", cnt1, 0);

        // Two back-to-back frames with en held
        push_frame1(1'b1, 1'b1);
        push_frame1(1'b0, 1'b0);
        @(negedge clk);
        en = 1'b1;
        k  = cyc;
        @(negedge clk);
        #1;
        check("start_latency", cyc - k, 1);
        check("start_fs", fs1, 1);
        check("start_busy", busy1, 1);
        check("start_cnt", cnt1, 1);
        t1 = cyc;
        idle_seen = 0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            if (busy1 !== 1'b1) idle_seen++;
            n++;
        end while (fs1 !== 1'b1 && n < 3000);
        check("frame_period", cyc - t1, 2432);
        check("frame2_cnt", cnt1, 2);
        check("no_idle_between", idle_seen, 0);
        t2 = cyc;

        // Drop en in frame 2 payload: frame must still complete
        repeat (320) @(negedge clk);
        en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy1 !== 1'b0 && n < 3000);
        check("frame2_end_time", cyc - t2, 2432);
        check("end_bit", bit1, 0);
        check("end_cnt", cnt1, 2);
        check("end_queue_empty", q1.size(), 0);
        base = n_stb1;
        repeat (40) @(negedge clk);
        #1;
        check("idle_no_strobe", n_stb1 - base, 0);

        // Reset at preamble bit 10
        push_frame1(1'b1, 1'b0);
        base = n_stb1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (n_stb1 < base + 11 && n < 300);
        check("reached_pre_bit10", n_stb1 - base, 11);
        rst = 1'b1;
        q1.delete();
        m_lfsr = 15'h7FFF;
        #1;
        check("abort_stb", stb1, 0);
        check("abort_busy", busy1, 0);
        check("abort_cnt", cnt1, 0);
        check("abort_bit", bit1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = n_stb1;
        repeat (5) @(negedge clk);
        #1;
        check("post_rst_no_strobe", n_stb1 - base, 0);

        // Fresh frame after reset; en dropped in payload
        push_frame1(1'b1, 1'b1);
        @(negedge clk);
        en = 1'b1;
        k  = cyc;
        @(negedge clk);
        #1;
        check("restart_latency", cyc - k, 1);
        check("restart_fs", fs1, 1);
        check("restart_cnt", cnt1, 1);
        t1 = cyc;
        repeat (320) @(negedge clk);
        en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy1 !== 1'b0 && n < 3000);
        check("single_frame_time", cyc - t1, 2432);
        check("single_cnt", cnt1, 1);
        check("single_bit", bit1, 0);
        check("single_queue_empty", q1.size(), 0);
        base = n_stb1;
        repeat (40) @(negedge clk);
        #1;
        check("single_no_strobe", n_stb1 - base, 0);

        // Small configuration: 1010 + PRBS + 0000, 32-cycle frames
        rst2 = 1'b0;
        push_small(16'hAFF0, 1'b1);
        push_small(16'hAFE0, 1'b0);
        @(negedge clk);
        en2 = 1'b1;
        k   = cyc;
        @(negedge clk);
        #1;
        check("small_latency", cyc - k, 1);
        check("small_fs", fs2, 1);
        t1 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (fs2 !== 1'b1 && n < 100);
        check("small_period", cyc - t1, 32);
        check("small_cnt", cnt2, 2);
        t2 = cyc;
        en2 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy2 !== 1'b0 && n < 100);
        check("small_end_time", cyc - t2, 32);
        check("small_queue_empty", q2.size(), 0);
        base = n_stb2;
        repeat (10) @(negedge clk);
        #1;
        check("small_no_strobe", n_stb2 - base, 0);
        check("small_end_cnt", cnt2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_source.md
FRAME_SOURCE -- requirements
Module: frame_source

Interface
REQ-001 Parameter BIT_DIV, default 8: clocks per output bit; legal values are 2 or more.
REQ-002 Parameter PRE_LEN, default 32: preamble length in bits; multiple of 4; legal range 4 to 32.
REQ-003 Parameter PRE_WORD, default 32'h1ACFFC1D: preamble pattern, sent MSB-first from bit PRE_LEN-1.
REQ-004 Parameter PAY_LEN, default 256: payload length in bits; multiple of 4.
REQ-005 Parameter GAP_LEN, default 16: inter-frame gap length in bits; multiple of 4.
REQ-006 Parameter LFSR_SEED, default 15'h7FFF: PRBS register seed; must be nonzero.
REQ-007 CLK  input  1  system clock; all logic on rising edge.
REQ-008 Rst  input  1  reset; asynchronous, active-high.
REQ-009 en  input  1  frame enable; sampled each cycle.
REQ-010 Bit  output  1  serial bit to the bit-to-code converter; registered; held between strobes.
REQ-011 bit_stb  output  1  one-cycle pulse in the cycle Bit takes a new value.
REQ-012 frame_start  output  1  one-cycle pulse coincident with the bit_stb of preamble bit 0.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 frame_cnt  output  16  count of frames started; wraps from 16'hFFFF to 0.

Function
REQ-015 The state machine SHALL have four states: IDLE, PRE, PAY and GAP.
REQ-016 IDLE: Bit=0, bit_stb=0, divider held at 0; en=1 sampled -> next cycle state=PRE, Bit=PRE_WORD[PRE_LEN-1], bit_stb=1, frame_start=1, frame_cnt+1.
REQ-017 Outside IDLE, the divider SHALL count 0..BIT_DIV-1 and wrap; each new bit and its bit_stb SHALL occur exactly BIT_DIV cycles after the previous one.
REQ-018 PRE: bit n SHALL be PRE_WORD[PRE_LEN-1-n]; after PRE_LEN bits, the next strobe SHALL emit payload bit 0 in state PAY.
REQ-019 PAY: Bit SHALL be lfsr[14]; after each payload bit the LFSR SHALL shift left with lfsr[0] <= lfsr[14]^lfsr[13] (PRBS-15, x^15+x^14+1).
REQ-020 The LFSR SHALL advance only on payload bits and SHALL persist across frames; it is reloaded with LFSR_SEED only by reset.
REQ-021 After PAY_LEN payload bits, the block SHALL emit GAP_LEN zero bits in state GAP, one per strobe.
REQ-022 End of the last gap bit period with en=1: the next strobe (BIT_DIV cycles after the last gap strobe) SHALL be preamble bit 0 with frame_start=1; there is no idle cycle.
REQ-023 End of the last gap bit period with en=0: the next cycle SHALL enter IDLE with Bit=0 and busy=0.
REQ-024 Deasserting en mid-frame SHALL NOT truncate the frame; the frame always completes through GAP.
REQ-025 Frame length is PRE_LEN+PAY_LEN+GAP_LEN bits (default 304), a multiple of 4, so 4-bit symbol alignment downstream is preserved across frames.
REQ-026 frame_cnt SHALL increment in the same cycle as frame_start.

Reset
REQ-027 While Rst=1, the block SHALL set state=IDLE, divider=0, lfsr=LFSR_SEED, and Bit, bit_stb, frame_start, busy and frame_cnt to 0.
REQ-028 Rst asserted mid-frame SHALL abort immediately; after release, a frame SHALL start only per REQ-016.

Verification
REQ-029 Rst release, en=1 at cycle k -> frame_start and bit_stb at k+1; 32 bits at 8-cycle spacing equal 0x1ACFFC1D MSB-first; busy=1.
REQ-030 Default seed -> first 16 payload bits are 0xFFFE (15 ones, then 0); the 16 gap bits are all 0.
REQ-031 en held high -> second frame_start exactly 2432 cycles after the first; frame_cnt=2; no IDLE cycle between frames.
REQ-032 en dropped during payload of frame 1 -> payload and gap complete, then busy=0, Bit=0, no further bit_stb; frame_cnt=1.
REQ-033 Rst pulsed at preamble bit 10 -> all outputs 0 immediately; after re-enable, preamble restarts at bit 0 and the payload again begins with 0xFFFE.
REQ-034 BIT_DIV=2, PRE_LEN=4, PRE_WORD=4'hA, PAY_LEN=8, GAP_LEN=4 -> bit_stb every 2 cycles; bits 1,0,1,0, then 8 PRBS bits, then 4 zeros; frame period 32 cycles.
